// File: rtl/tanh_fp16_arbiter.sv
// rtl/tanh_fp16_arbiter.sv - round-robin sharing of one fixed-latency tanh unit
// with a tag pipeline and credit-protected per-requester response FIFOs.
module tanh_fp16_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int LATENCY    = 5,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [16*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [16*NUM_REQ-1:0]  rsp_data,
  output logic                   pe_ivalid,
  output logic [15:0]            pe_datain,
  output logic                   pe_oready,
  input  logic [15:0]            pe_dataout,
  output logic                   busy
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);

  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  owner;
  logic [IDW-1:0]  grant_id;
  logic            grant_any;
  int              sel_idx;

  logic [CW-1:0]   credit [NUM_REQ];
  logic [LATENCY-1:0] tag_v;
  logic [IDW-1:0]  tag_id [LATENCY];

  logic [15:0]     mem    [NUM_REQ][FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr [NUM_REQ];
  logic [AW-1:0]   rd_ptr [NUM_REQ];
  logic [AW:0]     count  [NUM_REQ];

  logic [NUM_REQ-1:0] push;
  logic [NUM_REQ-1:0] pop;
  logic [NUM_REQ-1:0] grant_vec;

  // First eligible requester at or after the pointer, wrapping.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    sel_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel_idx = (int'(ptr) + k) % NUM_REQ;
      if (!grant_any && req_valid[sel_idx] && (credit[sel_idx] != '0)) begin
        grant_any = 1'b1;
        grant_id  = IDW'(sel_idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    grant_vec = '0;
    push      = '0;
    pop       = '0;
    rsp_valid = '0;
    rsp_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_vec[i] = grant_any && !reset && (grant_id == IDW'(i));
      req_ready[i] = grant_vec[i];
      push[i]      = tag_v[LATENCY-1] && (tag_id[LATENCY-1] == IDW'(i));
      rsp_valid[i] = (count[i] != '0);
      pop[i]       = rsp_valid[i] && rsp_ready[i];
      if (rsp_valid[i]) rsp_data[16*i +: 16] = mem[i][rd_ptr[i]];
    end
  end

  assign pe_oready = 1'b1;
  assign busy      = (|tag_v) | pe_ivalid | (|rsp_valid);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr       <= '0;
      owner     <= '0;
      pe_ivalid <= 1'b0;
      pe_datain <= '0;
    end else begin
      pe_ivalid <= grant_any;
      if (grant_any) begin
        pe_datain <= req_data[16*int'(grant_id) +: 16];
        owner     <= grant_id;
        ptr       <= (grant_id == IDW'(NUM_REQ-1)) ? '0 : grant_id + IDW'(1);
      end
    end
  end

  // Tag stage LATENCY lines up with pe_dataout from the matching issue.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tag_v <= '0;
      for (int k = 0; k < LATENCY; k++) tag_id[k] <= '0;
    end else begin
      tag_v     <= {tag_v[LATENCY-2:0], pe_ivalid};
      tag_id[0] <= owner;
      for (int k = 1; k < LATENCY; k++) tag_id[k] <= tag_id[k-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
        credit[i] <= CW'(FIFO_DEPTH);
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + (AW+1)'(1);
          2'b01:   count[i] <= count[i] - (AW+1)'(1);
          default: count[i] <= count[i];
        endcase
        case ({grant_vec[i], pop[i]})
          2'b10:   credit[i] <= credit[i] - CW'(1);
          2'b01:   credit[i] <= credit[i] + CW'(1);
          default: credit[i] <= credit[i];
        endcase
      end
    end
  end

  // Storage is not reset; validity comes from count.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= pe_dataout;
    end
  end

endmodule

// File: tb/tb_tanh_fp16_arbiter.sv
// tb/tb_tanh_fp16_arbiter.sv - randomized bench for tanh_fp16_arbiter with
// a behavioural tanh unit and a per-requester scoreboard.
module tb_tanh_fp16_arbiter;
  localparam int N = 4;
  localparam int L = 5;
  localparam int D = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_ready;
  logic [16*N-1:0] req_data = '0;
  logic [N-1:0]  rsp_valid;
  logic [N-1:0]  rsp_ready = '0;
  logic [16*N-1:0] rsp_data;
  logic          pe_ivalid;
  logic [15:0]   pe_datain;
  logic          pe_oready;
  logic [15:0]   pe_dataout;
  logic          busy;

  int checks = 0;
  int errors = 0;

  tanh_fp16_arbiter #(.NUM_REQ(N), .LATENCY(L), .FIFO_DEPTH(D)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .pe_ivalid(pe_ivalid), .pe_datain(pe_datain), .pe_oready(pe_oready),
    .pe_dataout(pe_dataout), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] tanh_ref(input logic [15:0] x);
    case (x)
      16'h0000: tanh_ref = 16'h0000;
      16'h3C00: tanh_ref = 16'h3A18;
      16'hBC00: tanh_ref = 16'hBA18;
      16'h4400: tanh_ref = 16'h3BFF;
      default:  tanh_ref = {x[15], x[14:0] ^ 15'h2A5A};
    endcase
  endfunction

  // Shared unit: fixed latency, never reset, never stalls.
  logic [15:0] pe_pipe [L];
  always @(posedge clock) begin
    pe_pipe[0] <= tanh_ref(pe_datain);
    for (int k = 1; k < L; k++) pe_pipe[k] <= pe_pipe[k-1];
  end
  assign pe_dataout = pe_pipe[L-1];

  // Reference: outstanding = granted but not yet popped; credit = D - outstanding.
  logic [15:0] exp_q [N][$];
  int out_m [N];
  int ptr_m = 0;

  always @(negedge clock) begin
    logic [N-1:0] exp_rdy;
    logic found;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        exp_q[i].delete();
        out_m[i] = 0;
      end
      ptr_m = 0;
    end else begin
      exp_rdy = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (ptr_m + k) % N;
        if (!found && req_valid[idx] && (D - out_m[idx]) > 0) begin
          exp_rdy[idx] = 1'b1;
          found = 1'b1;
        end
      end
      checks = checks + 1;
      if (req_ready !== exp_rdy) begin
        errors = errors + 1;
        $display("FAIL req_ready got=%b exp=%b t=%0t", req_ready, exp_rdy, $time);
      end
      for (int i = 0; i < N; i++) begin
        if (rsp_valid[i] && exp_q[i].size() == 0) begin
          errors = errors + 1;
          $display("FAIL spurious_rsp req=%0d got=1 exp=0 t=%0t", i, $time);
        end else if (rsp_valid[i] && rsp_ready[i]) begin
          checks = checks + 1;
          if (rsp_data[16*i +: 16] !== exp_q[i][0]) begin
            errors = errors + 1;
            $display("FAIL rsp_data req=%0d got=%h exp=%h t=%0t", i, rsp_data[16*i +: 16], exp_q[i][0], $time);
          end
          void'(exp_q[i].pop_front());
          out_m[i] = out_m[i] - 1;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_q[i].push_back(tanh_ref(req_data[16*i +: 16]));
          out_m[i] = out_m[i] + 1;
          ptr_m = (i + 1) % N;
        end
        if (out_m[i] < 0 || out_m[i] > D) begin
          errors = errors + 1;
          $display("FAIL credit_range req=%0d got=%0d exp=0..%0d", i, D - out_m[i], D);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic drain(output logic ok);
    ok = 1'b0;
    req_valid = '0;
    rsp_ready = '1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    tick();
    reset = 1'b1;
    req_valid = '1;
    #2;
    checks = checks + 1;
    if ({req_ready, rsp_valid, pe_ivalid, busy, pe_oready} !== {4'b0, 4'b0, 1'b0, 1'b0, 1'b1}) begin
      errors = errors + 1;
      $display("FAIL reset_ctrl got=%b exp=%b", {req_ready, rsp_valid, pe_ivalid, busy, pe_oready}, 11'b1);
    end
    checks = checks + 1;
    if (rsp_data !== 64'h0 || pe_datain !== 16'h0) begin
      errors = errors + 1;
      $display("FAIL reset_data got=%h/%h exp=0/0", rsp_data, pe_datain);
    end
    tick();
    req_valid = '0;
    reset = 1'b0;
  endtask

  task automatic test_single();
    int n;
    logic seen;
    do_reset();
    rsp_ready = '1;
    req_data[15:0] = 16'h3C00;
    req_valid = 4'b0001;
    @(negedge clock);
    checks = checks + 1;
    if (req_ready !== 4'b0001) begin
      errors = errors + 1;
      $display("FAIL single_grant got=%b exp=0001", req_ready);
    end
    n = 0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clock);
      n = n + 1;
      #1 req_valid = '0;
      @(negedge clock);
      if (rsp_valid[0]) begin
        seen = 1'b1;
        break;
      end
    end
    checks = checks + 1;
    if (!seen || n != L + 2) begin
      errors = errors + 1;
      $display("FAIL single_latency got=%0d exp=%0d", n, L + 2);
    end
    checks = checks + 1;
    if (rsp_data[15:0] !== 16'h3A18 || busy !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL single_data got=%h busy=%b exp=3a18 busy=1", rsp_data[15:0], busy);
    end
    @(negedge clock);
    checks = checks + 1;
    if (busy !== 1'b0 || rsp_valid !== 4'b0) begin
      errors = errors + 1;
      $display("FAIL single_idle got=%b/%b exp=0/0000", busy, rsp_valid);
    end
  endtask

  task automatic test_all_four();
    logic [N-1:0] exp_r;
    logic ok;
    do_reset();
    rsp_ready = '1;
    req_data = {16'h4400, 16'hBC00, 16'h3C00, 16'h0000};
    req_valid = 4'b1111;
    for (int k = 0; k < N; k++) begin
      @(negedge clock);
      exp_r = 4'b0001 << k;
      checks = checks + 1;
      if (req_ready !== exp_r) begin
        errors = errors + 1;
        $display("FAIL all_four_order step=%0d got=%b exp=%b", k, req_ready, exp_r);
      end
      tick();
      req_valid[k] = 1'b0;
    end
    drain(ok);
    checks = checks + 1;
    if (!ok) begin
      errors = errors + 1;
      $display("FAIL all_four_drain got=busy exp=idle");
    end
  endtask

  task automatic test_credit();
    int g0, miss1;
    logic ok;
    do_reset();
    rsp_ready = 4'b0010;
    req_valid = 4'b0011;
    g0 = 0;
    miss1 = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (req_ready[0]) g0 = g0 + 1;
      if (c >= 20 && !req_ready[1]) miss1 = miss1 + 1;
      tick();
      req_data = {$urandom, $urandom};
    end
    checks = checks + 1;
    if (g0 != D) begin
      errors = errors + 1;
      $display("FAIL credit_grants got=%0d exp=%0d", g0, D);
    end
    checks = checks + 1;
    if (miss1 != 0) begin
      errors = errors + 1;
      $display("FAIL credit_other got=%0d exp=0", miss1);
    end
    rsp_ready[0] = 1'b1;
    tick();
    rsp_ready[0] = 1'b0;
    g0 = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (req_ready[0]) g0 = g0 + 1;
      tick();
      req_data = {$urandom, $urandom};
    end
    checks = checks + 1;
    if (g0 != 1) begin
      errors = errors + 1;
      $display("FAIL credit_refill got=%0d exp=1", g0);
    end
    drain(ok);
    checks = checks + 1;
    if (!ok) begin
      errors = errors + 1;
      $display("FAIL credit_drain got=busy exp=idle");
    end
  endtask

  task automatic test_grant_pop();
    int g;
    logic ok;
    do_reset();
    req_valid = 4'b0100;
    g = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clock);
      if (req_ready[2]) g = g + 1;
      tick();
      req_data[47:32] = 16'($urandom);
    end
    checks = checks + 1;
    if (g != D || req_ready[2] !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL gp_fill got=%0d/%b exp=%0d/0", g, req_ready[2], D);
    end
    rsp_ready[2] = 1'b1;
    @(negedge clock);
    checks = checks + 1;
    if (req_ready[2] !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL gp_zero_credit got=%b exp=0", req_ready[2]);
    end
    tick();
    rsp_ready[2] = 1'b0;
    @(negedge clock);
    checks = checks + 1;
    if (req_ready[2] !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL gp_next_grant got=%b exp=1", req_ready[2]);
    end
    tick();
    req_valid = '0;
    rsp_ready[2] = 1'b1;
    tick();
    req_valid = 4'b0100;
    @(negedge clock);
    checks = checks + 1;
    if (req_ready[2] !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL gp_same_cycle got=%b exp=1", req_ready[2]);
    end
    tick();
    rsp_ready[2] = 1'b0;
    @(negedge clock);
    checks = checks + 1;
    if (req_ready[2] !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL gp_credit_kept got=%b exp=1", req_ready[2]);
    end
    tick();
    @(negedge clock);
    checks = checks + 1;
    if (req_ready[2] !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL gp_credit_used got=%b exp=0", req_ready[2]);
    end
    drain(ok);
    checks = checks + 1;
    if (!ok) begin
      errors = errors + 1;
      $display("FAIL gp_drain got=busy exp=idle");
    end
  endtask

  task automatic test_reset_mid();
    int bad, g;
    logic ok;
    do_reset();
    req_data = {$urandom, $urandom};
    req_valid = 4'b0111;
    for (int c = 0; c < 4; c++) tick();
    req_valid = '0;
    tick();
    tick();
    @(posedge clock);
    #3 reset = 1'b1;
    req_valid = 4'b1111;
    #1;
    checks = checks + 1;
    if ({req_ready, rsp_valid, pe_ivalid, busy} !== 10'b0 || rsp_data !== 64'h0 || pe_datain !== 16'h0) begin
      errors = errors + 1;
      $display("FAIL mid_reset got=%b/%h/%h exp=0", {req_ready, rsp_valid, pe_ivalid, busy}, rsp_data, pe_datain);
    end
    tick();
    tick();
    reset = 1'b0;
    req_valid = '0;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (rsp_valid !== 4'b0) bad = bad + 1;
    end
    checks = checks + 1;
    if (bad != 0) begin
      errors = errors + 1;
      $display("FAIL mid_no_rsp got=%0d exp=0", bad);
    end
    tick();
    req_valid = 4'b0011;
    @(negedge clock);
    checks = checks + 1;
    if (req_ready !== 4'b0001) begin
      errors = errors + 1;
      $display("FAIL mid_pointer got=%b exp=0001", req_ready);
    end
    tick();
    req_valid = 4'b0001;
    g = 1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clock);
      if (req_ready[0]) g = g + 1;
      tick();
    end
    checks = checks + 1;
    if (g != D) begin
      errors = errors + 1;
      $display("FAIL mid_credits got=%0d exp=%0d", g, D);
    end
    drain(ok);
    checks = checks + 1;
    if (!ok) begin
      errors = errors + 1;
      $display("FAIL mid_drain got=busy exp=idle");
    end
  endtask

  task automatic test_fairness();
    int bad, wait0, wait3, maxw;
    logic [N-1:0] exp_r;
    logic ok;
    do_reset();
    rsp_ready = '1;
    req_valid = 4'b1001;
    bad = 0;
    wait0 = 0;
    wait3 = 0;
    maxw = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clock);
      exp_r = (c % 2 == 0) ? 4'b0001 : 4'b1000;
      if (req_ready !== exp_r) bad = bad + 1;
      wait0 = req_ready[0] ? 0 : wait0 + 1;
      wait3 = req_ready[3] ? 0 : wait3 + 1;
      if (wait0 > maxw) maxw = wait0;
      if (wait3 > maxw) maxw = wait3;
      tick();
      req_data = {$urandom, $urandom};
    end
    checks = checks + 1;
    if (bad != 0) begin
      errors = errors + 1;
      $display("FAIL fair_alternate got=%0d exp=0", bad);
    end
    checks = checks + 1;
    if (maxw >= N) begin
      errors = errors + 1;
      $display("FAIL fair_wait got=%0d exp<%0d", maxw, N);
    end
    drain(ok);
    checks = checks + 1;
    if (!ok) begin
      errors = errors + 1;
      $display("FAIL fair_drain got=busy exp=idle");
    end
  endtask

  task automatic test_random();
    int left;
    logic ok;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom);
      rsp_ready = N'($urandom);
      req_data = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) req_data[15:0] = 16'h3C00;
      tick();
    end
    drain(ok);
    checks = checks + 1;
    if (!ok) begin
      errors = errors + 1;
      $display("FAIL random_drain got=busy exp=idle");
    end
    left = 0;
    for (int i = 0; i < N; i++) left = left + exp_q[i].size();
    checks = checks + 1;
    if (left != 0) begin
      errors = errors + 1;
      $display("FAIL random_leftover got=%0d exp=0", left);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_credit();
    test_grant_pop();
    test_reset_mid();
    test_fairness();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule

// File: doc/tanh_fp16_arbiter.md
Name: tanh_fp16_arbiter

Overview:
- Shares one fixed-latency tanh_fp16_top pipeline among NUM_REQ independent requesters.
- Round-robin arbitration issues at most one fp16 operand per cycle into the shared unit.
- A tag pipeline tracks the owner of each in-flight operand; results are steered into per-requester response FIFOs.
- Per-requester credits guarantee a result never arrives at a full FIFO, so the shared pipeline never stalls.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LATENCY, 5, cycles from pe_ivalid/pe_datain sampled to pe_dataout valid (5 for A10 build, 7 for S10 build).
- FIFO_DEPTH, 8, per-requester response FIFO entries (power of two, >= 2).

Ports:
- clock  in  1  single clock, all logic rising-edge.
- reset  in  1  asynchronous, active-high; clears all state.
- req_valid  in  NUM_REQ  requester i has an operand.
- req_ready  out  NUM_REQ  operand of requester i accepted this cycle.
- req_data  in  16*NUM_REQ  fp16 operand, requester i at bits [16i+15:16i].
- rsp_valid  out  NUM_REQ  FIFO i non-empty.
- rsp_ready  in  NUM_REQ  requester i pops its FIFO head.
- rsp_data  out  16*NUM_REQ  FIFO i head, same packing as req_data.
- pe_ivalid  out  1  registered; operand valid to the shared tanh unit.
- pe_datain  out  16  registered operand to the tanh unit.
- pe_oready  out  1  constant 1; the unit is never back-pressured.
- pe_dataout  in  16  tanh result, valid LATENCY cycles after the matching pe_ivalid.
- busy  out  1  any tag in flight or any FIFO non-empty.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, pe_ivalid=0, pe_datain=0, busy=0, RR pointer=0, all tag valids=0, FIFOs empty, credit[i]=FIFO_DEPTH.
- Eligibility: requester i is eligible when req_valid[i]=1 and credit[i]>0.
- Grant selection: the first eligible index at or after the pointer, wrapping modulo NUM_REQ.
  - req_ready is combinational from req_valid, credit and pointer; it is one-hot or zero.
  - A handshake is req_valid[i] & req_ready[i].
- Pointer update on a grant: pointer becomes grant+1 mod NUM_REQ. With no grant the pointer holds.
- Issue: on the handshake edge, pe_datain<=req_data[i] and pe_ivalid<=1. pe_ivalid<=0 on edges without a grant.
- Tag pipeline: LATENCY-stage shift register of {valid, id}, loaded with {pe_ivalid, owner} in step with the issue registers.
  - The stage-LATENCY tag qualifies pe_dataout on the same edge.
  - When that tag is valid, pe_dataout is pushed into FIFO[id].
- Response timing: the first response is visible on rsp_valid LATENCY+2 cycles after the req handshake when the FIFO starts empty. Sequence: issue register, LATENCY pipeline cycles, FIFO write.
- Credits:
  - A grant to i decrements credit[i].
  - A pop on i (rsp_valid[i] & rsp_ready[i]) increments credit[i].
  - A grant and a pop in the same cycle leave credit[i] unchanged.
  - credit[i] + in-flight(i) + occupancy(i) always equals FIFO_DEPTH, so a FIFO push never finds the FIFO full.
- FIFO: first-word-fall-through; rsp_data is the head. Push and pop in the same cycle are both honoured.
- Ordering: per requester, responses come back in request order. No ordering is defined between requesters.
- Fairness: a continuously eligible requester is granted within NUM_REQ cycles.
- Reset mid-operation:
  - Tags, FIFOs and credits clear immediately.
  - In-flight results returning after reset are ignored because their tag valids are 0.
  - No spurious rsp_valid follows reset.
- busy = OR of all tag valids, pe_ivalid, and every FIFO non-empty.
- Assertions (bench):
  - push to a full FIFO never occurs;
  - credit stays within 0..FIFO_DEPTH;
  - req_ready is one-hot or zero.

Test Plan:
- Single request, DUT wired to tanh_fp16_top with BOARD_FAMILY_A10=1 and LATENCY=5: req 0 sends 0x3C00 with rsp_ready=1 -> rsp_valid[0] rises 7 cycles after the handshake with rsp_data=0x3A18; busy falls one cycle after the pop.
- All four requesters valid at once, pointer=0: operands 0x0000/0x3C00/0xBC00/0x4400 -> grants land on consecutive cycles in order 0,1,2,3. Responses are 0x0000, 0x3A18, 0xBA18 and the tanh(4.0) value from tanh_fp16_top, each landing in its own FIFO.
- Credit exhaustion: req 0 streams continuously with rsp_ready[0]=0 -> exactly 8 grants, then req_ready[0]=0. Requester 1 keeps receiving a grant every cycle. Popping one entry re-enables exactly one further grant.
- Simultaneous grant and pop on requester 2 with credit[2]=0 before the pop -> no grant that cycle (credit is 0); the next cycle grants. Credit ends unchanged across a same-cycle grant+pop.
- Reset asserted 3 cycles after 4 grants -> all outputs return to reset values asynchronously. No rsp_valid appears in the following 10 cycles. After release, credits are 8 and the pointer is 0.
- Fairness: req 0 and req 3 both always valid, FIFOs drained -> grants alternate 0,3,0,3 and no requester waits more than 4 cycles.
